// File: rtl/sum_arbiter_pkg.sv
// Shared types and default sizing for the round-robin adder arbiter.
package sum_arb_pkg;

    localparam int DEF_W       = 12;
    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/sum_arbiter_if.sv
// Requester-side bus of the arbiter: per-requester operands in, one-hot accept and response out.
interface sum_arbiter_if
    import sum_arb_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);

    logic [N-1:0]        req_valid;
    logic [N-1:0][W-1:0] req_a;
    logic [N-1:0][W-1:0] req_b;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [W-1:0]        rsp_data;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/sum_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick
    import sum_arb_pkg::*;
#(
    parameter int  N  = DEF_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one external adder among N requesters.
// Optional WAIT timeout abort is enabled by defining ARB_TIMEOUT_EN.
module sum_arbiter
    import sum_arb_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    sum_arbiter_if.slave bus,
    output logic         add_start,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_y,
    input  logic         add_valid,
    output logic         busy
);

    localparam int IW = $clog2(N);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [W-1:0]  add_a_q, add_a_d;
    logic [W-1:0]  add_b_q, add_b_d;
    logic          add_start_q, add_start_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;

    logic [N-1:0]  pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Accept is combinational from IDLE and forced low while reset is asserted.
    assign bus.req_ready = (rst_n && state_q == IDLE) ? pick_grant : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_start_d = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_idx;
                    add_a_d     = bus.req_a[pick_idx];
                    add_b_d     = bus.req_b[pick_idx];
                    add_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (add_valid) begin
                    rsp_data_d           = add_y;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d           = '0;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_start_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_start_q <= add_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign add_start     = add_start_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign busy          = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed self-checking bench for sum_arbiter with a one-cycle-latency adder model.
module tb_sum_arbiter;
    import sum_arb_pkg::*;

    localparam int W = 12;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         add_start;
    logic [W-1:0] add_a, add_b, add_y;
    logic         add_valid, busy;

    logic         model_valid, inj_valid, withhold;
    logic [W-1:0] model_y;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sum_arbiter_if #(.W(W), .N(N)) bus ();

    sum_arbiter #(.W(W), .N(N), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_y     (add_y),
        .add_valid (add_valid),
        .busy      (busy)
    );

    // Shared adder: result and strobe exactly one cycle after add_start, unless withheld.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_valid <= 1'b0;
            model_y     <= '0;
        end else begin
            model_valid <= add_start & ~withhold;
            model_y     <= add_a + add_b;
        end
    end

    assign add_valid = model_valid | inj_valid;
    assign add_y     = model_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_ready"},     32'(bus.req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(bus.rsp_data), 32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
        check({tag, "_add_start"}, 32'(add_start), 32'd0);
        check({tag, "_add_a"},     32'(add_a), 32'd0);
        check({tag, "_add_b"},     32'(add_b), 32'd0);
    endtask

    initial begin
        withhold      = 1'b0;
        inj_valid     = 1'b0;
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = '0;
            bus.req_b[i] = '0;
        end

        // Reset: accept suppressed even with every requester valid.
        #2;
        check_all_zero("reset");
        bus.req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single requester 0: 100 + 23.
        bus.req_a[0]  = 12'd100;
        bus.req_b[0]  = 12'd23;
        bus.req_valid = 4'b0001;
        #1;
        check("r0_ready_T", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = 4'b1111;
        #1;
        check("r0_start_T1", 32'(add_start), 32'd1);
        check("r0_add_a", 32'(add_a), 32'd100);
        check("r0_add_b", 32'(add_b), 32'd23);
        check("r0_busy_T1", 32'(busy), 32'd1);
        check("r0_ready_issue", 32'(bus.req_ready), 32'd0);
        tick();
        check("r0_start_T2", 32'(add_start), 32'd0);
        check("r0_rsp_T2", 32'(bus.rsp_valid), 32'd0);
        check("r0_ready_wait", 32'(bus.req_ready), 32'd0);
        tick();
        bus.req_valid = '0;
        check("r0_rsp_valid_T3", 32'(bus.rsp_valid), 32'b0001);
        check("r0_rsp_data_T3", 32'(bus.rsp_data), 32'd123);
        check("r0_rsp_err_T3", 32'(bus.rsp_err), 32'd0);
        tick();
        check("r0_rsp_T4", 32'(bus.rsp_valid), 32'd0);
        check("r0_busy_T4", 32'(busy), 32'd0);

        // Wrap-around sum on requester 2 (ptr now 1).
        bus.req_a[2]  = 12'd4095;
        bus.req_b[2]  = 12'd1;
        bus.req_valid = 4'b0100;
        #1;
        check("wrap_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("wrap_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        check("wrap_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("wrap_rsp_err", 32'(bus.rsp_err), 32'd0);
        tick();

        // Reset while requester 3 is in WAIT.
        bus.req_a[3]  = 12'd7;
        bus.req_b[3]  = 12'd8;
        bus.req_valid = 4'b1000;
        #1;
        check("rstw_ready", 32'(bus.req_ready), 32'b1000);
        tick();
        bus.req_valid = '0;
        check("rstw_add_a_pre", 32'(add_a), 32'd7);
        tick();
        check("rstw_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstw");
        tick();
        check("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // All requesters held valid: grants 0,1,2,3,0 four cycles apart.
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = 12'(10 * i + 1);
            bus.req_b[i] = 12'(i);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % N;
            #1;
            check($sformatf("rr%0d_ready", k), 32'(bus.req_ready), 32'(1 << e));
            tick();
            check($sformatf("rr%0d_start", k), 32'(add_start), 32'd1);
            check($sformatf("rr%0d_ready_issue", k), 32'(bus.req_ready), 32'd0);
            tick();
            tick();
            check($sformatf("rr%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(1 << e));
            check($sformatf("rr%0d_rsp_data", k), 32'(bus.rsp_data), 32'(11 * e + 1));
            tick();
        end
        bus.req_valid = '0;

        // Stray add_valid in IDLE is ignored.
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        check("stray_rsp_a", 32'(bus.rsp_valid), 32'd0);
        check("stray_busy_a", 32'(busy), 32'd0);
        tick();
        check("stray_rsp_b", 32'(bus.rsp_valid), 32'd0);
        check("stray_busy_b", 32'(busy), 32'd0);
        check("stray_start", 32'(add_start), 32'd0);

        // Adder withholds its strobe on requester 1 (ptr now 1).
        withhold      = 1'b1;
        bus.req_a[1]  = 12'd5;
        bus.req_b[1]  = 12'd6;
        bus.req_valid = 4'b0010;
        #1;
        check("to_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        repeat (8) tick();
        check("to_rsp_T9", 32'(bus.rsp_valid), 32'd0);
        check("to_busy_T9", 32'(busy), 32'd1);
        tick();
`ifdef ARB_TIMEOUT_EN
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("to_rsp_data", 32'(bus.rsp_data), 32'd0);
        tick();
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_err_after", 32'(bus.rsp_valid), 32'd0);
`else
        check("hold_busy_T10", 32'(busy), 32'd1);
        check("hold_rsp_T10", 32'(bus.rsp_valid), 32'd0);
        check("hold_err_T10", 32'(bus.rsp_err), 32'd0);
        repeat (20) tick();
        check("hold_busy_T30", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("hold_busy_reset", 32'(busy), 32'd0);
`endif
        withhold = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
